// File: rtl/sha_256_stream_core_if.sv
// sha_256_stream_core_if: block input and digest output handshakes of the SHA-256 stream core
interface sha_256_stream_core_if;
  logic [511:0] input_data;
  logic input_valid;
  logic input_first;
  logic input_last;
  logic mode_224;
  logic input_ready;
  logic [255:0] output_hash;
  logic output_valid;
  logic output_ready;
  modport master (
    output input_data, input_valid, input_first, input_last, mode_224, output_ready,
    input input_ready, output_hash, output_valid
  );
  modport slave (
    input input_data, input_valid, input_first, input_last, mode_224, output_ready,
    output input_ready, output_hash, output_valid
  );
endinterface

// File: rtl/sha_256_stream_core.sv
// sha_256_stream_core: multi-block SHA-256/SHA-224 compression engine with chained hash state
module sha_256_stream_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit ENABLE_SHA224 = 1
) (
  input logic clk,
  input logic rst,
  input logic ena,
  sha_256_stream_core_if.slave bus
);
  localparam int R = ROUNDS_PER_CYCLE;
  localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  typedef enum logic [1:0] {S_IDLE, S_ROUNDS, S_FINAL, S_OUTPUT} state_t;
  state_t state, nxt;
  logic [0:7][31:0] h, v, nv;
  logic [0:15][31:0] w, nw;
  logic [5:0] cnt;
  logic last_q, mode_q, accept, m224;
  logic [255:0] iv;
  if (R != 1 && R != 2 && R != 4) begin : g_bad_rounds
    $error("ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [0:7][31:0] rnd(input logic [0:7][31:0] s, input logic [31:0] k, input logic [31:0] wt);
    logic [31:0] t1, t2;
    t1 = s[7] + (ror(s[4], 6) ^ ror(s[4], 11) ^ ror(s[4], 25)) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + wt;
    t2 = (ror(s[0], 2) ^ ror(s[0], 13) ^ ror(s[0], 22)) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    return {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
  endfunction
  // Window always holds W[t..t+15]; the word pushed in is W[t+16].
  function automatic logic [0:15][31:0] shift(input logic [0:15][31:0] x);
    return {x[1:15], (ror(x[14], 17) ^ ror(x[14], 19) ^ (x[14] >> 10)) + x[9]
                   + (ror(x[1], 7) ^ ror(x[1], 18) ^ (x[1] >> 3)) + x[0]};
  endfunction
  assign m224 = ENABLE_SHA224 && bus.mode_224;
  assign iv = m224 ? IV224 : IV256;
  assign bus.input_ready = ena && state == S_IDLE;
  assign accept = bus.input_valid && bus.input_ready;
  assign bus.output_valid = state == S_OUTPUT;
  assign bus.output_hash = mode_q ? {h[0:6], 32'h0} : h;
  always_comb begin
    nv = v;
    nw = w;
    for (int j = 0; j < R; j++) begin
      nv = rnd(nv, K[cnt + 6'(j)], nw[0]);
      nw = shift(nw);
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = bus.input_valid ? S_ROUNDS : S_IDLE;
      S_ROUNDS: nxt = cnt == 6'(64 - R) ? S_FINAL : S_ROUNDS;
      S_FINAL:  nxt = last_q ? S_OUTPUT : S_IDLE;
      default:  nxt = bus.output_ready ? S_IDLE : S_OUTPUT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else if (ena) state <= nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      h <= IV256;
      cnt <= '0;
      mode_q <= 1'b0;
      last_q <= 1'b0;
    end else if (ena) begin
      if (accept) begin
        if (bus.input_first) begin
          h <= iv;
          mode_q <= m224;
        end
        v <= bus.input_first ? iv : h;
        w <= bus.input_data;
        cnt <= '0;
        last_q <= bus.input_last;
      end else if (state == S_ROUNDS) begin
        v <= nv;
        w <= nw;
        cnt <= cnt + 6'(R);
      end else if (state == S_FINAL) begin
        for (int i = 0; i < 8; i++) h[i] <= h[i] + v[i];
      end
    end
  end
endmodule

// File: tb/tb_sha_256_stream_core.sv
// tb_sha_256_stream_core: scoreboard bench over R=1/2/4 cores sharing one stimulus driver
module tb_sha_256_stream_core;
  localparam logic [255:0] IV256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] H_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] H_224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
  localparam logic [255:0] H_2B = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] H_E = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0] B_ABC = {32'h61626380, 448'h0, 32'h18};
  localparam logic [511:0] B_E = {32'h80000000, 480'h0};
  localparam logic [511:0] B_0 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                  32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                  32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                  32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B_1 = {480'h0, 32'h1c0};
  logic clk = 0, rst = 1, ena = 1;
  logic [511:0] data = '0;
  logic valid = 0, first = 0, last = 0, m224 = 0, oready = 1;
  int sel = 0, cyc = 0, n_chk = 0, n_fail = 0;
  logic rdy, ov, ov_q = 0;
  logic [255:0] oh;
  logic [255:0] exp_h[$];
  int exp_c[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  sha_256_stream_core_if b1 ();
  sha_256_stream_core_if b2 ();
  sha_256_stream_core_if b4 ();
  sha_256_stream_core #(.ROUNDS_PER_CYCLE(1)) u1 (.clk(clk), .rst(rst), .ena(ena), .bus(b1));
  sha_256_stream_core #(.ROUNDS_PER_CYCLE(2)) u2 (.clk(clk), .rst(rst), .ena(ena), .bus(b2));
  sha_256_stream_core #(.ROUNDS_PER_CYCLE(4)) u4 (.clk(clk), .rst(rst), .ena(ena), .bus(b4));
  assign b1.input_data = data;
  assign b1.input_first = first;
  assign b1.input_last = last;
  assign b1.mode_224 = m224;
  assign b1.input_valid = valid && sel == 0;
  assign b1.output_ready = oready && sel == 0;
  assign b2.input_data = data;
  assign b2.input_first = first;
  assign b2.input_last = last;
  assign b2.mode_224 = m224;
  assign b2.input_valid = valid && sel == 1;
  assign b2.output_ready = oready && sel == 1;
  assign b4.input_data = data;
  assign b4.input_first = first;
  assign b4.input_last = last;
  assign b4.mode_224 = m224;
  assign b4.input_valid = valid && sel == 2;
  assign b4.output_ready = oready && sel == 2;
  assign rdy = sel == 0 ? b1.input_ready : sel == 1 ? b2.input_ready : b4.input_ready;
  assign ov = sel == 0 ? b1.output_valid : sel == 1 ? b2.output_valid : b4.output_valid;
  assign oh = sel == 0 ? b1.output_hash : sel == 1 ? b2.output_hash : b4.output_hash;
  task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Monitor: each new digest is checked against the oldest expected digest and arrival cycle.
  always @(negedge clk) begin
    if (ov && !ov_q) begin
      if (exp_h.size() == 0) chk("spurious_digest", 256'(exp_h.size()), 256'd1);
      else begin
        chk("digest", oh, exp_h.pop_front());
        chk("digest_latency", 256'(cyc), 256'(exp_c.pop_front()));
      end
    end
    ov_q <= ov;
  end
  task automatic send(input logic [511:0] d, input logic f, input logic l, input logic m,
                      input logic [255:0] eh, input int lat);
    int n = 0;
    data = d; first = f; last = l; m224 = m; valid = 1;
    while (!rdy && n < 300) begin tick(); n++; end
    chk("accept_timeout", 256'(rdy), 256'd1);
    if (l) begin
      exp_h.push_back(eh);
      exp_c.push_back(cyc + 1 + lat);
    end
    tick();
    valid = 0;
  endtask
  task automatic wait_ready(input int lat);
    int n = 0;
    while (!rdy && n < 300) begin tick(); n++; end
    chk("ready_gap", 256'(n), 256'(lat));
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_h.size() != 0 || ov) && n < 500) begin tick(); n++; end
    chk("drain_timeout", 256'(n < 500), 256'd1);
  endtask
  task automatic two_block(input int lat);
    send(B_0, 1, 0, 0, '0, 0);
    wait_ready(lat);
    send(B_1, 0, 1, 0, H_2B, lat);
    drain();
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int low = 0, n = 0;
    repeat (3) tick();
    rst = 0;
    chk("reset_ready", 256'(rdy), 256'd1);
    chk("reset_valid", 256'(ov), 256'd0);
    chk("reset_hash", oh, IV256);
    send(B_ABC, 1, 1, 0, H_ABC, 65);
    drain();
    send(B_ABC, 1, 1, 1, H_224, 65);
    drain();
    two_block(65);
    oready = 0;
    send(B_E, 1, 1, 0, H_E, 65);
    while (!ov && n < 200) begin tick(); n++; end
    data = B_ABC; first = 1; last = 1; valid = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_valid", 256'(ov), 256'd1);
      chk("hold_hash", oh, H_E);
    end
    oready = 1;
    tick();
    chk("no_accept_on_release", 256'(rdy), 256'd1);
    valid = 0;
    drain();
    send(B_ABC, 1, 1, 0, H_ABC, 75);
    repeat (5) tick();
    for (int i = 0; i < 40; i++) begin
      ena = !(low < 10 && ($urandom_range(1, 0) == 1 || 40 - i <= 10 - low));
      if (!ena) low++;
      tick();
    end
    ena = 1;
    drain();
    send(B_ABC, 1, 0, 0, '0, 0);
    repeat (29) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("abort_valid", 256'(ov), 256'd0);
    chk("abort_ready", 256'(rdy), 256'd1);
    chk("abort_hash", oh, IV256);
    send(B_ABC, 0, 1, 0, H_ABC, 65);
    drain();
    sel = 1;
    two_block(33);
    sel = 2;
    two_block(17);
    chk("queue_empty", 256'(exp_h.size()), 256'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
